// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: funct3 decode, data memory sequencing, load extension.
// Define LSU_MISALIGN_EN to split misaligned half/word accesses into byte accesses.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_write,
  output logic [1:0]        mem_access_size,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
`ifdef LSU_MISALIGN_EN
    SPLIT  = 2'd2,
`endif
    RESP   = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] f3_q;
  logic       err_q;
  logic       illegal;
  logic       misaligned;

  assign req_ready = (state == IDLE);

  assign illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11) ||
                   (req_write && req_funct3[2]);
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  function automatic logic [DATA_W-1:0] extend(input logic [2:0] f, input logic [DATA_W-1:0] w);
    case (f)
      3'b000:  extend = {{(DATA_W-8){w[7]}}, w[7:0]};
      3'b001:  extend = {{(DATA_W-16){w[15]}}, w[15:0]};
      3'b100:  extend = {{(DATA_W-8){1'b0}}, w[7:0]};
      3'b101:  extend = {{(DATA_W-16){1'b0}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

`ifdef LSU_MISALIGN_EN
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_next;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nxt;
  logic              split_last;

  assign cnt_nxt    = cnt + 2'd1;
  assign split_last = (f3_q[1:0] == 2'b01) ? (cnt == 2'd1) : (cnt == 2'd3);

  always_comb begin
    asm_next = asm_q;
    asm_next[8*cnt +: 8] = mem_data_out[7:0];
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      f3_q            <= '0;
      err_q           <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
      mem_address     <= '0;
      mem_read_write  <= 1'b0;
      mem_access_size <= 2'd0;
      mem_data_in     <= '0;
`ifdef LSU_MISALIGN_EN
      addr_q          <= '0;
      wdata_q         <= '0;
      asm_q           <= '0;
      cnt             <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q <= req_funct3;
            // Errors still spend one cycle in ACCESS (memory idle) so all responses share latency.
            if (illegal) begin
              err_q <= 1'b1;
              state <= ACCESS;
            end
`ifdef LSU_MISALIGN_EN
            else if (misaligned) begin
              err_q           <= 1'b0;
              addr_q          <= req_addr;
              wdata_q         <= req_wdata;
              asm_q           <= '0;
              cnt             <= 2'd0;
              mem_address     <= req_addr;
              mem_access_size <= 2'd0;
              mem_read_write  <= req_write;
              mem_data_in     <= {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
              state           <= SPLIT;
            end
`else
            else if (misaligned) begin
              err_q <= 1'b1;
              state <= ACCESS;
            end
`endif
            else begin
              err_q           <= 1'b0;
              mem_address     <= req_addr;
              mem_access_size <= req_funct3[1:0];
              mem_read_write  <= req_write;
              mem_data_in     <= req_wdata;
              state           <= ACCESS;
            end
          end
        end
        ACCESS: begin
          resp_err        <= err_q;
          resp_rdata      <= (err_q || mem_read_write) ? '0 : extend(f3_q, mem_data_out);
          resp_valid      <= 1'b1;
          mem_read_write  <= 1'b0;
          mem_access_size <= 2'd0;
          state           <= RESP;
        end
`ifdef LSU_MISALIGN_EN
        SPLIT: begin
          asm_q <= asm_next;
          if (split_last) begin
            resp_err        <= 1'b0;
            resp_rdata      <= mem_read_write ? '0 : extend(f3_q, asm_next);
            resp_valid      <= 1'b1;
            mem_read_write  <= 1'b0;
            mem_access_size <= 2'd0;
            state           <= RESP;
          end else begin
            cnt         <= cnt_nxt;
            mem_address <= addr_q + {{(ADDR_W-2){1'b0}}, cnt_nxt};
            mem_data_in <= {{(DATA_W-8){1'b0}}, wdata_q[8*cnt_nxt +: 8]};
          end
        end
`endif
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte memory model, expected-response queue, response monitor.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_access_size(mem_access_size), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Byte memory indexed by the low address byte; reads return only the accessed size.
  logic [7:0] mem [256];
  logic [7:0] b0, b1, b2, b3;
  assign b0 = mem[mem_address[7:0]];
  assign b1 = mem[mem_address[7:0] + 8'd1];
  assign b2 = mem[mem_address[7:0] + 8'd2];
  assign b3 = mem[mem_address[7:0] + 8'd3];
  assign mem_data_out = (mem_access_size == 2'd0) ? {24'h0, b0} :
                        (mem_access_size == 2'd1) ? {16'h0, b1, b0} :
                        (mem_access_size == 2'd2) ? {b3, b2, b1, b0} : 32'h0;

  typedef struct { logic [31:0] a; logic [1:0] s; logic [31:0] d; } wr_t;
  wr_t wlog[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset && mem_read_write) begin
      wlog.push_back('{mem_address, mem_access_size, mem_data_in});
      mem[mem_address[7:0]] = mem_data_in[7:0];
      if (mem_access_size != 2'd0) mem[mem_address[7:0] + 8'd1] = mem_data_in[15:8];
      if (mem_access_size == 2'd2) begin
        mem[mem_address[7:0] + 8'd2] = mem_data_in[23:16];
        mem[mem_address[7:0] + 8'd3] = mem_data_in[31:24];
      end
    end
  end

  typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } exp_t;
  exp_t exp_q[$];

  bit          seen = 0;
  int          first_cyc;
  logic [31:0] hold_rdata;
  logic        hold_err;

  // Monitor: stability under back-pressure, then compare on each response handshake.
  always @(negedge clock) begin
    if (reset) seen = 0;
    else if (resp_valid) begin
      if (!seen) begin
        seen = 1; first_cyc = cyc; hold_rdata = resp_rdata; hold_err = resp_err;
      end else begin
        chk("rdata_stable", resp_rdata, hold_rdata);
        chk("err_stable", {31'h0, resp_err}, {31'h0, hold_err});
      end
      chk("req_ready_low", {31'h0, req_ready}, 32'h0);
      if (resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          chk("resp_latency", first_cyc - e.acc, e.lat);
        end
        seen = 0;
      end
    end
  end

  task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input int lat, input int bp, input int nw);
    int n;
    @(negedge clock);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    wlog.delete();
    req_valid = 1; req_write = w; req_funct3 = f; req_addr = a; req_wdata = d;
    resp_ready = (bp == 0);
    @(posedge clock); #1;
    exp_q.push_back('{er, ee, lat, cyc});
    req_valid = 0;
    if (bp > 0) begin
      repeat (bp + lat) @(posedge clock);
      #1 resp_ready = 1;
    end
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clock); #1; n++; end
    chk("req_done", {31'h0, req_ready}, 32'h1);
    chk("write_count", wlog.size(), nw);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_resp_err"}, {31'h0, resp_err}, 32'h0);
    chk({tag, "_mem_address"}, mem_address, 32'h0);
    chk({tag, "_mem_rw"}, {31'h0, mem_read_write}, 32'h0);
    chk({tag, "_mem_size"}, {30'h0, mem_access_size}, 32'h0);
    chk({tag, "_mem_data_in"}, mem_data_in, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h21; mem[1] = 8'h43; mem[2] = 8'h65; mem[3] = 8'h87; mem[255] = 8'h5A;
    reset = 1; req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 1;
    repeat (2) @(posedge clock);
    #1 chk_reset_outputs("reset");
    @(negedge clock) reset = 0;

    do_req(0, 3'b010, 32'h0100_0000, 0, 32'h8765_4321, 0, 1, 0, 0);
    do_req(0, 3'b000, 32'h0100_0003, 0, 32'hFFFF_FF87, 0, 1, 0, 0);
    do_req(0, 3'b100, 32'h0100_0003, 0, 32'h0000_0087, 0, 1, 0, 0);
    do_req(0, 3'b101, 32'h0100_0002, 0, 32'h0000_8765, 0, 1, 0, 0);
    do_req(0, 3'b001, 32'h0100_0002, 0, 32'hFFFF_8765, 0, 1, 0, 0);
    do_req(0, 3'b000, 32'h0100_0000, 0, 32'h0000_0021, 0, 1, 0, 0);
    do_req(1, 3'b010, 32'h0100_0004, 32'hDEAD_BEEF, 32'h0, 0, 1, 0, 1);
    if (wlog.size() == 1) begin
      chk("sw_addr", wlog[0].a, 32'h0100_0004);
      chk("sw_size", {30'h0, wlog[0].s}, 32'h2);
      chk("sw_data", wlog[0].d, 32'hDEAD_BEEF);
    end
    do_req(0, 3'b010, 32'h0100_0004, 0, 32'hDEAD_BEEF, 0, 1, 0, 0);
    do_req(1, 3'b000, 32'h0100_0001, 32'h1234_56AA, 32'h0, 0, 1, 0, 1);
    if (wlog.size() == 1) chk("sb_size", {30'h0, wlog[0].s}, 32'h0);
    do_req(0, 3'b010, 32'h0100_0000, 0, 32'h8765_AA21, 0, 1, 0, 0);
    do_req(1, 3'b001, 32'h0100_0002, 32'h1234_CAFE, 32'h0, 0, 1, 0, 1);
    do_req(0, 3'b010, 32'h0100_0000, 0, 32'hCAFE_AA21, 0, 1, 0, 0);
    do_req(0, 3'b011, 32'h0100_0000, 0, 32'h0, 1, 1, 0, 0);
    do_req(1, 3'b100, 32'h0100_0000, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, 0);
    do_req(0, 3'b110, 32'h0100_0000, 0, 32'h0, 1, 1, 0, 0);
    do_req(0, 3'b010, 32'h0100_0004, 0, 32'hDEAD_BEEF, 0, 1, 5, 0);

`ifdef LSU_MISALIGN_EN
    do_req(1, 3'b010, 32'h0100_0005, 32'h1122_3344, 32'h0, 0, 4, 0, 4);
    if (wlog.size() == 4) begin
      logic [31:0] sdat;
      sdat = 32'h1122_3344;
      for (int i = 0; i < 4; i++) begin
        chk("split_addr", wlog[i].a, 32'h0100_0005 + i);
        chk("split_size", {30'h0, wlog[i].s}, 32'h0);
        chk("split_byte", {24'h0, wlog[i].d[7:0]}, {24'h0, sdat[8*i +: 8]});
      end
    end
    do_req(0, 3'b010, 32'h0100_0005, 0, 32'h1122_3344, 0, 4, 0, 0);
    do_req(0, 3'b001, 32'h0100_0001, 0, 32'hFFFF_FEAA, 0, 2, 0, 0);
    do_req(0, 3'b101, 32'h0100_0007, 0, 32'h0000_1122, 0, 2, 0, 0);
    do_req(0, 3'b010, 32'hFFFF_FFFF, 0, 32'hFEAA_215A, 0, 4, 0, 0);
    // Abort a split store after its first byte has been written.
    @(negedge clock);
    req_valid = 1; req_write = 1; req_funct3 = 3'b010; req_addr = 32'h0100_0011;
    req_wdata = 32'h9988_7766;
    @(posedge clock); #1 req_valid = 0;
    @(posedge clock);
    @(negedge clock) reset = 1;
    #1 chk_reset_outputs("abort");
    chk("abort_byte0", {24'h0, mem[8'h11]}, 32'h66);
    chk("abort_byte1", {24'h0, mem[8'h12]}, 32'h00);
`else
    do_req(0, 3'b001, 32'h0100_0001, 0, 32'h0, 1, 1, 0, 0);
    do_req(1, 3'b010, 32'h0100_0005, 32'h1122_3344, 32'h0, 1, 1, 0, 0);
    do_req(0, 3'b010, 32'h0100_0006, 0, 32'h0, 1, 1, 0, 0);
    // Abort an aligned store during its access cycle.
    @(negedge clock);
    req_valid = 1; req_write = 1; req_funct3 = 3'b010; req_addr = 32'h0100_0010;
    req_wdata = 32'h9988_7766;
    @(posedge clock); #1 req_valid = 0;
    @(negedge clock) reset = 1;
    #1 chk_reset_outputs("abort");
    @(posedge clock); #1;
    chk("abort_nowrite", {24'h0, mem[8'h10]}, 32'h00);
`endif
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("post_abort_valid", {31'h0, resp_valid}, 32'h0);
    chk("post_abort_ready", {31'h0, req_ready}, 32'h1);
    do_req(0, 3'b010, 32'h0100_0000, 0, 32'hCAFE_AA21, 0, 1, 0, 0);
    chk("queue_empty", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
